// File: rtl/i2c_arbiter.sv
// ============================================================================
// i2c_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter and transaction sequencer that sits in front of a
// single i2c_master. Each of NUM_REQ clients asks for one 8-bit register read
// or write. The block grants one client at a time and runs the register-index
// byte phase, then the data byte phase (a write byte, or a read after a
// repeated start). It then returns read data and a status code to the client.
//
// Optional feature (macro I2C_ARB_RETRY_EN):
//   defined   - a NACK restarts the transaction from SEL, up to MAX_RETRIES
//               times per grant, before error 1 is reported.
//   undefined - the first NACK reports error 1 (MAX_RETRIES unused).
//
// Parameters:
//   NUM_REQ         number of clients (1..8)
//   TIMEOUT_CYCLES  clk_in cycles allowed per byte phase, 0 = no timeout
//   MAX_RETRIES     NACK retries per transaction (retry build only)
//
// Ports:
//   clk_in, RESETn            clock, asynchronous active-low reset
//   req / req_*               per-client request and packed request fields
//                             (slice i belongs to client i)
//   grant                     one-hot, held from acceptance through rsp_valid
//   rsp_valid/rdata/err       one-cycle completion pulse, read data, status
//                             (0 ok, 1 NACK, 2 bus error, 3 timeout)
//   m_address, m_data_tx,     command side of the i2c_master handshake
//   m_transfer_start,
//   m_transfer_continues
//   m_transfer_ready,         status side of the i2c_master handshake
//   m_interrupt, m_nack,
//   m_*_err, m_data_rx,
//   m_transaction_complete
// ============================================================================
module i2c_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4800000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                 clk_in,
    input  logic                 RESETn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_dev_addr,
    input  logic [8*NUM_REQ-1:0] req_reg,
    input  logic [NUM_REQ-1:0]   req_write,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic [7:0]           m_address,
    output logic                 m_transfer_start,
    output logic                 m_transfer_continues,
    output logic [7:0]           m_data_tx,
    input  logic                 m_transfer_ready,
    input  logic                 m_interrupt,
    input  logic                 m_transaction_complete,
    input  logic                 m_nack,
    input  logic                 m_address_err,
    input  logic                 m_start_err,
    input  logic                 m_arbitration_err,
    input  logic [7:0]           m_data_rx
);

    if (NUM_REQ < 1 || NUM_REQ > 8 || MAX_RETRIES < 0) begin : g_param_check
        $error("i2c_arbiter: NUM_REQ must be 1..8 and MAX_RETRIES >= 0");
    end

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Last counter value of a byte phase: the next count would reach the limit.
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, SEL, REG, REG_WAIT, DATA, DATA_WAIT, RESP
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_BUS     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    state_t               state_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        gnt_idx_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [6:0]           dev_q;
    logic [7:0]           reg_q;
    logic                 write_q;
    logic [7:0]           wdata_q;
    logic [TW-1:0]        tcnt_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [7:0]           rsp_rdata_q;
    logic [1:0]           rsp_err_q;
    logic [7:0]           m_address_q;
    logic                 m_transfer_start_q;
    logic                 m_transfer_continues_q;
    logic [7:0]           m_data_tx_q;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at or after rr_ptr_q, wrapping.
    // Walking the offsets from highest to lowest lets the lowest offset
    // (the closest requester) win without a break.
    // ------------------------------------------------------------------
    logic                 sel_valid;
    logic [IW-1:0]        sel_idx;
    logic [6:0]           sel_dev;
    logic [7:0]           sel_reg;
    logic                 sel_write;
    logic [7:0]           sel_wdata;

    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first, so no path through the block can infer a latch.
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_dev   = '0;
        sel_reg   = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(idx);
                sel_dev   = req_dev_addr[7*idx +: 7];
                sel_reg   = req_reg[8*idx +: 8];
                sel_write = req_write[idx];
                sel_wdata = req_wdata[8*idx +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte-phase outcome, shared by REG_WAIT and DATA_WAIT. A NACK takes
    // priority over the bus error flags; the timeout is only considered
    // in cycles without an interrupt.
    // ------------------------------------------------------------------
    logic bus_err;
    logic timeout_hit;
    logic retry_ok;
    logic phase_retry;
    logic phase_fail;
    err_t fail_code;

    assign bus_err     = m_address_err | m_start_err | m_arbitration_err;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (tcnt_q == T_LAST);

`ifdef I2C_ARB_RETRY_EN
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RW-1:0] retry_q;
    assign retry_ok = (int'(retry_q) < MAX_RETRIES);
`else
    assign retry_ok = 1'b0;
`endif

    always_comb begin
        phase_retry = 1'b0;
        phase_fail  = 1'b0;
        fail_code   = ERR_OK;
        if (m_interrupt) begin
            if (m_nack) begin
                if (retry_ok) begin
                    phase_retry = 1'b1;
                end else begin
                    phase_fail = 1'b1;
                    fail_code  = ERR_NACK;
                end
            end else if (bus_err) begin
                phase_fail = 1'b1;
                fail_code  = ERR_BUS;
            end
        end else if (timeout_hit) begin
            phase_fail = 1'b1;
            fail_code  = ERR_TIMEOUT;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer. All outputs are registered; start pulses and rsp_valid
    // are set on the edge that enters REG/DATA/RESP and cleared on the
    // edge that leaves them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge RESETn) begin
        if (!RESETn) begin
            // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
            state_q                <= IDLE;
            rr_ptr_q               <= '0;
            gnt_idx_q              <= '0;
            grant_q                <= '0;
            dev_q                  <= '0;
            reg_q                  <= '0;
            write_q                <= 1'b0;
            wdata_q                <= '0;
            tcnt_q                 <= '0;
            rsp_valid_q            <= '0;
            rsp_rdata_q            <= '0;
            rsp_err_q              <= '0;
            m_address_q            <= '0;
            m_transfer_start_q     <= 1'b0;
            m_transfer_continues_q <= 1'b0;
            m_data_tx_q            <= '0;
`ifdef I2C_ARB_RETRY_EN
            retry_q                <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        gnt_idx_q <= sel_idx;
                        grant_q   <= NUM_REQ'(1) << sel_idx;
                        dev_q     <= sel_dev;
                        reg_q     <= sel_reg;
                        write_q   <= sel_write;
                        wdata_q   <= sel_wdata;
`ifdef I2C_ARB_RETRY_EN
                        retry_q   <= '0;
`endif
                        state_q   <= SEL;
                    end
                end

                SEL: begin
                    if (m_transfer_ready) begin
                        m_address_q            <= {dev_q, 1'b0};
                        m_data_tx_q            <= reg_q;
                        m_transfer_continues_q <= 1'b1;
                        m_transfer_start_q     <= 1'b1;
                        tcnt_q                 <= '0;
                        state_q                <= REG;
                    end
                end

                REG: begin
                    m_transfer_start_q <= 1'b0;
                    tcnt_q             <= tcnt_q + 1'b1;
                    state_q            <= REG_WAIT;
                end

                REG_WAIT: begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (phase_retry) begin
`ifdef I2C_ARB_RETRY_EN
                        retry_q <= retry_q + 1'b1;
`endif
                        state_q <= SEL;
                    end else if (phase_fail) begin
                        rsp_valid_q <= grant_q;
                        rsp_err_q   <= fail_code;
                        rsp_rdata_q <= '0;
                        state_q     <= RESP;
                    end else if (m_interrupt) begin
                        // Reads switch the address to mode 1, so the master
                        // issues a repeated start for the data byte.
                        m_address_q            <= {dev_q, ~write_q};
                        m_data_tx_q            <= write_q ? wdata_q : 8'h00;
                        m_transfer_continues_q <= 1'b0;
                        m_transfer_start_q     <= 1'b1;
                        tcnt_q                 <= '0;
                        state_q                <= DATA;
                    end
                end

                DATA: begin
                    m_transfer_start_q <= 1'b0;
                    tcnt_q             <= tcnt_q + 1'b1;
                    state_q            <= DATA_WAIT;
                end

                DATA_WAIT: begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (phase_retry) begin
`ifdef I2C_ARB_RETRY_EN
                        retry_q <= retry_q + 1'b1;
`endif
                        state_q <= SEL;
                    end else if (phase_fail) begin
                        rsp_valid_q <= grant_q;
                        rsp_err_q   <= fail_code;
                        rsp_rdata_q <= '0;
                        state_q     <= RESP;
                    end else if (m_interrupt && m_transaction_complete) begin
                        rsp_valid_q <= grant_q;
                        rsp_err_q   <= ERR_OK;
                        rsp_rdata_q <= write_q ? 8'h00 : m_data_rx;
                        state_q     <= RESP;
                    end
                end

                RESP: begin
                    rsp_valid_q <= '0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= '0;
                    grant_q     <= '0;
                    rr_ptr_q    <= (int'(gnt_idx_q) == NUM_REQ - 1) ? '0 : gnt_idx_q + 1'b1;
                    state_q     <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant                = grant_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_rdata            = rsp_rdata_q;
    assign rsp_err              = rsp_err_q;
    assign m_address            = m_address_q;
    assign m_transfer_start     = m_transfer_start_q;
    assign m_transfer_continues = m_transfer_continues_q;
    assign m_data_tx            = m_data_tx_q;

endmodule
